// File: rtl/truth_table_sweeper.sv
// Sweeps all eight input vectors of a 3-input gate, samples its output after a
// programmable settle time and compares the measured truth table to an expected one.
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] expected,
  output logic [2:0] gate_in,
  input  logic       gate_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       match,
  output logic [7:0] mismatch_mask
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [2:0]       idx_reg, idx_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       shadow_reg, shadow_next;
  logic [7:0]       exp_reg, exp_next;
  logic [7:0]       table_reg, table_next;
  logic             match_reg, match_next;
  logic [7:0]       mask_reg, mask_next;

  logic             sample_fire;
  logic             shadow_clear;
  logic [7:0]       shadow_we;

  // State register plus all datapath registers; every one returns to zero on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      cnt_reg    <= '0;
      shadow_reg <= '0;
      exp_reg    <= '0;
      table_reg  <= '0;
      match_reg  <= 1'b0;
      mask_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      cnt_reg    <= cnt_next;
      shadow_reg <= shadow_next;
      exp_reg    <= exp_next;
      table_reg  <= table_next;
      match_reg  <= match_next;
      mask_reg   <= mask_next;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    cnt_next     = cnt_reg;
    exp_next     = exp_reg;
    table_next   = table_reg;
    match_next   = match_reg;
    mask_next    = mask_reg;
    sample_fire  = 1'b0;
    shadow_clear = 1'b0;
    gate_in      = 3'd0;
    busy         = 1'b0;
    done         = 1'b0;

    case (state_reg)
      IDLE: begin
        // abort takes priority over a simultaneous start
        if (start && !abort) begin
          exp_next     = expected;
          idx_next     = 3'd0;
          cnt_next     = '0;
          shadow_clear = 1'b1;
          state_next   = SETTLE;
        end
      end

      SETTLE: begin
        gate_in  = idx_reg;
        busy     = 1'b1;
        cnt_next = cnt_reg + CNT_W'(1);
        if (abort) begin
          state_next = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = SAMPLE;
        end
      end

      SAMPLE: begin
        gate_in = idx_reg;
        busy    = 1'b1;
        if (abort) begin
          state_next = IDLE;
        end else begin
          sample_fire = 1'b1;
          if (idx_reg == 3'd7) begin
            state_next = FINISH;
          end else begin
            idx_next   = idx_reg + 3'd1;
            cnt_next   = '0;
            state_next = SETTLE;
          end
        end
      end

      FINISH: begin
        done       = 1'b1;
        table_next = shadow_reg;
        match_next = (shadow_reg == exp_reg);
        mask_next  = shadow_reg ^ exp_reg;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One write enable per truth-table bit, selected by the current vector index.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_shadow_we
      assign shadow_we[gi] = sample_fire && (idx_reg == 3'(gi));
    end
  endgenerate

  always_comb begin
    shadow_next = shadow_reg;
    if (shadow_clear) begin
      shadow_next = '0;
    end else begin
      shadow_next = (shadow_reg & ~shadow_we) | (shadow_we & {8{gate_out}});
    end
  end

  assign table_out     = table_reg;
  assign match         = match_reg;
  assign mismatch_mask = mask_reg;

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Sequencer that characterises one 3-input combinational gate block in the gate library (input {in1,in2,in3}, single output). It drives all 8 input combinations in ascending order and holds each for a programmable settle time. It then samples the gate output and assembles the measured 8-bit truth table. The result is compared against a caller-supplied expected table. It sits between a test/config host and one gate instance and owns the gate's inputs for the whole sweep.

Parameters:
SETTLE_CYCLES, 4, number of cycles each vector is held before sampling; legal range 1..255
CNT_W, 8, width of the settle counter; must satisfy 2^CNT_W > SETTLE_CYCLES

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a sweep; honoured only in IDLE
abort  input  1  cancel sweep in progress
expected  input  8  expected truth table; bit i = output for {in1,in2,in3}=i; captured on accepted start
gate_in  output  3  drives {in1,in2,in3} of the gate under test
gate_out  input  1  output of the gate under test
busy  output  1  high from the cycle after accepted start until the FINISH cycle, exclusive
done  output  1  one-cycle pulse when a sweep completes
table_out  output  8  last completed measured truth table
match  output  1  table_out == captured expected, for last completed sweep
mismatch_mask  output  8  table_out XOR captured expected

Behaviour:
- Reset (async assert, sync release): state=IDLE; gate_in=0, busy=0, done=0, table_out=0, match=0, mismatch_mask=0, internal index/counter/shadow table=0.
- States: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE: gate_in=0. If start=1 and abort=0: capture expected, set idx=0, clear shadow table and counter, go to SETTLE.
- SETTLE: gate_in=idx. Counter increments each cycle. When counter==SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE: gate_in=idx. shadow[idx] <= gate_out. If idx==7, go to FINISH. Otherwise idx <= idx+1, counter <= 0, go to SETTLE.
- Each vector is held SETTLE_CYCLES+1 cycles. gate_out is sampled on the last of those cycles. Vector order is 0..7 with no wrap.
- FINISH (one cycle): gate_in=0, done=1, table_out <= shadow, match and mismatch_mask update from shadow and captured expected in the same edge. Then go to IDLE.
- Latency: start accepted at cycle T. done is high during cycle T+1+8*(SETTLE_CYCLES+1). Results are visible from the cycle after done.
- busy=1 in SETTLE and SAMPLE only.
- start while not IDLE is ignored. It does not queue. start during FINISH is ignored.
- abort=1 in SETTLE or SAMPLE: next state IDLE and gate_in=0 next cycle. No done. table_out, match and mismatch_mask retain previous values.
- abort in IDLE or FINISH has no effect. abort and start together in IDLE: abort wins, no sweep.
- expected changes after acceptance have no effect on the running sweep.
- Reset mid-sweep: immediate return to reset values, including table_out=0. No done.
- table_out, match and mismatch_mask change only in the FINISH edge or on reset.

Test Plan:
- Gate model with output 1 only for inputs 3, 6 and 7; SETTLE_CYCLES=4; expected=8'hC8; start pulse at T. Required: gate_in steps 0..7, each value held 5 cycles; done at T+41; table_out=8'hC8; match=1; mismatch_mask=8'h00.
- Same gate model with expected=8'hC9. Required: table_out=8'hC8, match=0, mismatch_mask=8'h01.
- Gate model with output delayed 3 cycles and SETTLE_CYCLES=4 versus SETTLE_CYCLES=1. Required: 8'hC8 with SETTLE_CYCLES=4. With SETTLE_CYCLES=1 each sample sees the previous vector's response, giving 8'h90 (= 8'hC8 << 1), not 8'hC8.
- Start pulses during busy and in the FINISH cycle, plus expected toggled mid-sweep. Required: exactly one done, with result judged against the originally captured expected.
- Complete sweep giving 8'hC8, then a second sweep aborted while idx=4. Required: gate_in=0 next cycle, busy=0, no done, table_out stays 8'hC8.
- rst_n pulled low while idx=5. Required: all outputs 0 asynchronously. A new start after release produces a full correct sweep.
